// File: rtl/pipeline_ctrl.sv
// Run-lifecycle sequencer and hazard controller; enables are combinational from state and ID/EX inputs.
// Load-use and memory stalls hold PC and IF/ID; memory-busy also freezes the rest of the pipe.
module pipeline_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             dmem_busy_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             id_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_en_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUN     = 3'd1;
  localparam logic [2:0] MEMWAIT = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] HALTED  = 3'd4;

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DW-1:0]    drain_cnt;
  logic [DW-1:0]    drain_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic load_use;
  logic live;
  logic stall_evt;
  logic flush_evt;
  logic halt_evt;
  logic count_cycle;

  // MEMWAIT with memory ready behaves exactly like RUN for hazards, counters and halt
  assign load_use    = ex_memread_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign live        = ((state == RUN) || (state == MEMWAIT)) && !dmem_busy_i;
  assign stall_evt   = live && load_use;
  assign flush_evt   = live && !load_use && id_branch_taken_i;
  assign halt_evt    = live && !load_use && halt_i;
  assign count_cycle = (state == RUN) || (state == MEMWAIT) || (state == DRAIN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = RUN;
      end
      RUN, MEMWAIT: begin
        if (dmem_busy_i) begin
          state_nxt = MEMWAIT;
        end else if (halt_evt) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LOAD;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (!dmem_busy_i) begin
          if (drain_cnt == '0) state_nxt = HALTED;
          else                 drain_nxt = drain_cnt - DRAIN_ONE;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    case (state)
      RUN, MEMWAIT: begin
        if (!dmem_busy_i) begin
          pipe_en_o = 1'b1;
          if (load_use) begin
            // branch in ID waits; it re-resolves once the load has moved on
            idex_bubble_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = id_branch_taken_i;
          end
        end
      end
      DRAIN: begin
        ifid_flush_o = 1'b1;
        pipe_en_o    = !dmem_busy_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (count_cycle && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (stall_evt && !(&stall_cnt))   stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && !(&flush_cnt))   flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign state_o     = state;
  assign cycle_cnt_o = cycle_cnt;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl; a second 3-bit-counter instance exercises saturation.
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  logic rst_i, start_i, halt_i, dmem_busy_i, ex_memread_i, id_branch_taken_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_en;
  logic [2:0] s_state, s_cycle_cnt, s_stall_cnt, s_flush_cnt;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.CNT_W(32), .DRAIN_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .dmem_busy_i(dmem_busy_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .pipe_en_o(pipe_en_o), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipeline_ctrl #(.CNT_W(3), .DRAIN_CYCLES(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .dmem_busy_i(dmem_busy_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
    .idex_bubble_o(s_idex_bubble), .pipe_en_o(s_pipe_en), .state_o(s_state),
    .cycle_cnt_o(s_cycle_cnt), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  // {state, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en}
  logic [7:0] comb_o;
  assign comb_o = {state_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o};

  localparam int C_IDLE  = 'h00;
  localparam int C_RUN   = 'h39;
  localparam int C_LU    = 'h23;
  localparam int C_BR    = 'h3D;
  localparam int C_FRZ1  = 'h20;
  localparam int C_FRZ2  = 'h40;
  localparam int C_MW_BR = 'h5D;
  localparam int C_DR    = 'h65;
  localparam int C_DRB   = 'h64;
  localparam int C_HLT   = 'h80;

  typedef struct packed {
    logic start, halt, busy, mr;
    logic [4:0] rd, rs1, rs2;
    logic br;
  } stim_t;

  typedef struct packed {
    stim_t s;
    logic [7:0] comb;
    logic [2:0] nst;
    logic dc, ds, df;
  } step_t;

  typedef struct packed {
    logic [7:0]  comb;
    logic [2:0]  nst;
    logic [31:0] cyc, stl, fl;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] sat_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ecyc, estl, efl;

  function automatic step_t mk(int start, int halt, int busy, int mr, int rd, int rs1, int rs2,
                               int br, int comb, int nst, int dc, int ds, int df);
    step_t t;
    t.s.start = (start != 0); t.s.halt = (halt != 0); t.s.busy = (busy != 0);
    t.s.mr = (mr != 0); t.s.rd = 5'(rd); t.s.rs1 = 5'(rs1); t.s.rs2 = 5'(rs2);
    t.s.br = (br != 0); t.comb = 8'(comb); t.nst = 3'(nst);
    t.dc = (dc != 0); t.ds = (ds != 0); t.df = (df != 0);
    return t;
  endfunction

  function automatic logic [2:0] sat3(int v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  task automatic drive(input stim_t s);
    start_i = s.start; halt_i = s.halt; dmem_busy_i = s.busy; ex_memread_i = s.mr;
    ex_rd_i = s.rd; id_rs1_i = s.rs1; id_rs2_i = s.rs2; id_branch_taken_i = s.br;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t e;
    rst_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if (comb_o !== 8'h00) begin n_bad++; $display("FAIL reset_outputs got %h want 00", comb_o); end
    n_cmp++;
    if ({cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin
      n_bad++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cycle_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    rst_i = 1'b1;
    ecyc = 0; estl = 0; efl = 0;
    st.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, C_IDLE, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i].s);
      ecyc += 32'(st[i].dc); estl += 32'(st[i].ds); efl += 32'(st[i].df);
      exp_q.push_back('{st[i].comb, st[i].nst, ecyc, estl, efl});
      @(negedge clk_i);
      e = exp_q[0];
      n_cmp++;
      if (comb_o !== e.comb) begin n_bad++; $display("FAIL idle[%0d] outputs got %h want %h", i, comb_o, e.comb); end
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL idle[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 0, 0, 1, 5, 1, 5, 0, C_LU,  1, 1, 1, 0));
    st.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, C_RUN, 1, 1, 0, 0));
    st.push_back(mk(1, 0, 0, 1, 7, 7, 3, 0, C_LU,  1, 1, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 7, 7, 3, 0, C_RUN, 1, 1, 0, 0));
    st.push_back(mk(1, 0, 0, 1, 9, 3, 4, 0, C_RUN, 1, 1, 0, 0));
    foreach (st[i]) begin
      drive(st[i].s);
      ecyc += 32'(st[i].dc); estl += 32'(st[i].ds); efl += 32'(st[i].df);
      exp_q.push_back('{st[i].comb, st[i].nst, ecyc, estl, efl});
      @(negedge clk_i);
      e = exp_q[0];
      n_cmp++;
      if (comb_o !== e.comb) begin n_bad++; $display("FAIL load_use[%0d] outputs got %h want %h", i, comb_o, e.comb); end
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL load_use[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
    end
  endtask

  task automatic test_branch_priority();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 0, 0, 1, 4, 4, 0, 1, C_LU,  1, 1, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 4, 4, 0, 1, C_BR,  1, 1, 0, 1));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 1, 0, 0));
    foreach (st[i]) begin
      drive(st[i].s);
      ecyc += 32'(st[i].dc); estl += 32'(st[i].ds); efl += 32'(st[i].df);
      exp_q.push_back('{st[i].comb, st[i].nst, ecyc, estl, efl});
      @(negedge clk_i);
      e = exp_q[0];
      n_cmp++;
      if (comb_o !== e.comb) begin n_bad++; $display("FAIL branch[%0d] outputs got %h want %h", i, comb_o, e.comb); end
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL branch[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
    end
  endtask

  task automatic test_memwait();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ1,  2, 1, 0, 0));
    st.push_back(mk(1, 0, 1, 1, 6, 6, 6, 0, C_FRZ2,  2, 1, 0, 0));
    st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, C_FRZ2,  2, 1, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_MW_BR, 1, 1, 0, 1));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 1, 0, 0));
    foreach (st[i]) begin
      drive(st[i].s);
      ecyc += 32'(st[i].dc); estl += 32'(st[i].ds); efl += 32'(st[i].df);
      exp_q.push_back('{st[i].comb, st[i].nst, ecyc, estl, efl});
      @(negedge clk_i);
      e = exp_q[0];
      n_cmp++;
      if (comb_o !== e.comb) begin n_bad++; $display("FAIL memwait[%0d] outputs got %h want %h", i, comb_o, e.comb); end
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL memwait[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
    end
  endtask

  task automatic test_halt_drain();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 1, 0, 1, 2, 2, 0, 0, C_LU,  1, 1, 1, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, C_RUN, 3, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DR,  3, 1, 0, 0));
    st.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, C_DRB, 3, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DR,  3, 1, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DR,  3, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DR,  4, 1, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HLT, 4, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 3, 3, 3, 1, C_HLT, 4, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, C_HLT, 4, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i].s);
      ecyc += 32'(st[i].dc); estl += 32'(st[i].ds); efl += 32'(st[i].df);
      exp_q.push_back('{st[i].comb, st[i].nst, ecyc, estl, efl});
      @(negedge clk_i);
      e = exp_q[0];
      n_cmp++;
      if (comb_o !== e.comb) begin n_bad++; $display("FAIL halt_drain[%0d] outputs got %h want %h", i, comb_o, e.comb); end
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL halt_drain[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
    end
  endtask

  task automatic test_async_reset();
    rst_i = 1'b0;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (3) begin
      drive(mk(1, 0, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 0).s);
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if ({state_o, stall_cnt_o} !== {3'd1, 32'd3}) begin
      n_bad++; $display("FAIL pre_reset st/stl got %0d/%0d want 1/3", state_o, stall_cnt_o);
    end
    #1;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (comb_o !== 8'h00) begin n_bad++; $display("FAIL async_reset outputs got %h want 00", comb_o); end
    n_cmp++;
    if ({cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin
      n_bad++; $display("FAIL async_reset counters got %0d/%0d/%0d want 0/0/0", cycle_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
    @(posedge clk_i); #1;
    n_cmp++;
    if ({state_o, cycle_cnt_o} !== {3'd1, 32'd0}) begin
      n_bad++; $display("FAIL restart st/cyc got %0d/%0d want 1/0", state_o, cycle_cnt_o);
    end
  endtask

  task automatic test_saturation();
    logic [8:0] se;
    exp_t e;
    for (int i = 0; i < 19; i++) begin
      if (i < 10) drive(mk(1, 0, 0, 1, 3, 0, 3, 0, 0, 0, 0, 0, 0).s);
      else        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0).s);
      exp_q.push_back('{8'h00, 3'd1, 32'(i + 1), 32'((i < 10) ? i + 1 : 10), 32'((i < 10) ? 0 : i - 9)});
      sat_q.push_back({sat3(i + 1), sat3((i < 10) ? i + 1 : 10), sat3((i < 10) ? 0 : i - 9)});
      @(posedge clk_i); #1;
      e  = exp_q.pop_front();
      se = sat_q.pop_front();
      n_cmp++;
      if ({state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== {e.nst, e.cyc, e.stl, e.fl}) begin
        n_bad++;
        $display("FAIL sat_wide[%0d] st/cyc/stl/fl got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, e.nst, e.cyc, e.stl, e.fl);
      end
      n_cmp++;
      if ({s_cycle_cnt, s_stall_cnt, s_flush_cnt} !== se) begin
        n_bad++;
        $display("FAIL sat_narrow[%0d] cyc/stl/fl got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 s_cycle_cnt, s_stall_cnt, s_flush_cnt, se[8:6], se[5:3], se[2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_memwait();
    test_halt_drain();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim time expired, bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
